sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like port between an instruction fetch
// requester and a load/store requester, one transaction in flight at a time.
// Data wins by default; a bounded starvation counter forces an inst grant.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          run_q;
  logic          win_inst, win_inst_nxt;
  logic          lat_wr, lat_wr_nxt;
  logic [SW-1:0] lat_wstrb, lat_wstrb_nxt;
  logic [AW-1:0] lat_addr, lat_addr_nxt;
  logic [DW-1:0] lat_wdata, lat_wdata_nxt;
  logic          grant_inst;
  logic          grant_data;
  logic          in_addr;
  logic          in_data;

  // State and latched-request registers; run_q holds off grants for the first
  // cycle after reset release so release is seen synchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      run_q      <= 1'b0;
      win_inst   <= 1'b0;
      lat_wr     <= 1'b0;
      lat_wstrb  <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      run_q      <= 1'b1;
      win_inst   <= win_inst_nxt;
      lat_wr     <= lat_wr_nxt;
      lat_wstrb  <= lat_wstrb_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, wait for accept in ADDR, completion in DATA.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    win_inst_nxt   = win_inst;
    lat_wr_nxt     = lat_wr;
    lat_wstrb_nxt  = lat_wstrb;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    grant_inst     = 1'b0;
    grant_data     = 1'b0;
    case (state)
      IDLE: begin
        if (run_q) begin
          if (inst_req && (!data_req || (starve_cnt == LIMIT))) begin
            grant_inst = 1'b1;
          end else if (data_req) begin
            grant_data = 1'b1;
          end
        end
        if (grant_inst) begin
          state_nxt      = ADDR;
          win_inst_nxt   = 1'b1;
          lat_wr_nxt     = 1'b0;
          lat_wstrb_nxt  = '0;
          lat_addr_nxt   = inst_addr;
          lat_wdata_nxt  = '0;
          starve_cnt_nxt = '0;
        end else if (grant_data) begin
          state_nxt     = ADDR;
          win_inst_nxt  = 1'b0;
          lat_wr_nxt    = data_wr;
          lat_wstrb_nxt = data_wstrb;
          lat_addr_nxt  = data_addr;
          lat_wdata_nxt = data_wdata;
          if (inst_req && (starve_cnt < LIMIT)) begin
            starve_cnt_nxt = starve_cnt + CW'(1);
          end
        end
      end
      ADDR: begin
        if (sram_addr_ok) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (sram_data_ok) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: memory fields only while requesting, handshakes routed to
  // the winner, read data passed through only during the completion cycle.
  always_comb begin
    in_addr      = (state == ADDR);
    in_data      = (state == DATA);
    sram_req     = in_addr;
    sram_wr      = in_addr & lat_wr;
    sram_wstrb   = in_addr ? lat_wstrb : '0;
    sram_addr    = in_addr ? lat_addr  : '0;
    sram_wdata   = in_addr ? lat_wdata : '0;
    inst_addr_ok = in_addr & sram_addr_ok &  win_inst;
    data_addr_ok = in_addr & sram_addr_ok & ~win_inst;
    inst_data_ok = in_data & sram_data_ok &  win_inst;
    data_data_ok = in_data & sram_data_ok & ~win_inst;
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end

endmodule
